// File: rtl/random_perm_stream_if.sv
// Element stream carrying one permutation entry per beat with valid/ready flow control.
interface random_perm_stream_if #(
   parameter int LOG_N = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [LOG_N-1:0] out_data;
   logic             out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/random_perm_stream.sv
// Fisher-Yates permutation generator: shuffles an N-entry table with a Galois LFSR,
// then streams the entries out over a valid/ready interface.
module random_perm_stream #(
   parameter int                LOG_N  = 4,
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 shuffle_en,
   input  logic                 seed_load,
   input  logic [LFSR_W-1:0]    seed,
   output logic                 busy,
   output logic                 done,
   random_perm_stream_if.master out
);
   localparam int N = 1 << LOG_N;
   localparam int PW = 2 * LOG_N + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_INIT    = 2'd1,
      S_SHUFFLE = 2'd2,
      S_OUT     = 2'd3
   } state_t;

   state_t                    state_r, state_s;
   logic [LFSR_W-1:0]         lfsr_r;
   logic [N-1:0][LOG_N-1:0]   table_r, table_s;
   logic [LOG_N-1:0]          idx_r, idx_inc_s, j_s, data_r;
   logic [PW-1:0]             prod_s;
   logic                      shuffle_r, valid_r, last_r, done_r, busy_r;
   logic                      accept_s, load_s, xfer_s;

   function automatic logic [N-1:0][LOG_N-1:0] ident_f();
      logic [N-1:0][LOG_N-1:0] t;
      for (int k = 0; k < N; k++) t[k] = LOG_N'(k);
      return t;
   endfunction

   assign prod_s    = PW'(lfsr_r[LOG_N-1:0]) * (PW'(idx_r) + PW'(1));
   assign j_s       = LOG_N'(prod_s >> LOG_N);
   assign idx_inc_s = idx_r + LOG_N'(1);
   assign xfer_s    = valid_r && out.out_ready;

   // Next-state decode and acceptance strobes
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      load_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            load_s = seed_load;
            if (start) begin
               accept_s = 1'b1;
               state_s  = S_INIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_INIT: begin
            if (shuffle_r) state_s = S_SHUFFLE;
            else           state_s = S_OUT;
         end
         S_SHUFFLE: begin
            if (idx_r == LOG_N'(1)) state_s = S_OUT;
            else                    state_s = S_SHUFFLE;
         end
         S_OUT: begin
            if (xfer_s && last_r) state_s = S_IDLE;
            else                  state_s = S_OUT;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Table update: identity on INIT, swap entries i and j on each shuffle step
   always_comb begin
      table_s = table_r;
      if (state_r == S_INIT) begin
         table_s = ident_f();
      end else if (state_r == S_SHUFFLE) begin
         table_s[idx_r] = table_r[j_s];
         table_s[j_s]   = table_r[idx_r];
      end else begin
         table_s = table_r;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_r <= S_IDLE;
      else      state_r <= state_s;
   end

   // Datapath: LFSR, table, index and registered output stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_r    <= SEED;
         table_r   <= ident_f();
         idx_r     <= '0;
         shuffle_r <= 1'b0;
         valid_r   <= 1'b0;
         data_r    <= '0;
         last_r    <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         table_r <= table_s;
         done_r  <= 1'b0;
         busy_r  <= (state_s != S_IDLE);
         case (state_r)
            S_IDLE: begin
               if (load_s) lfsr_r <= (seed == '0) ? SEED : seed;
               if (accept_s) shuffle_r <= shuffle_en;
            end
            S_INIT: begin
               // Shuffle walks i down from N-1; identity output starts straight at k = 0
               if (shuffle_r) idx_r <= LOG_N'(N - 1);
               else           idx_r <= '0;
            end
            S_SHUFFLE: begin
               lfsr_r <= (lfsr_r >> 1) ^ (lfsr_r[0] ? TAPS : '0);
               idx_r  <= idx_r - LOG_N'(1);
            end
            S_OUT: begin
               if (!valid_r) begin
                  valid_r <= 1'b1;
                  data_r  <= table_r[idx_r];
                  last_r  <= (idx_r == LOG_N'(N - 1));
               end else if (out.out_ready) begin
                  if (last_r) begin
                     valid_r <= 1'b0;
                     data_r  <= '0;
                     last_r  <= 1'b0;
                     done_r  <= 1'b1;
                     idx_r   <= '0;
                  end else begin
                     idx_r  <= idx_inc_s;
                     data_r <= table_r[idx_inc_s];
                     last_r <= (idx_inc_s == LOG_N'(N - 1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign out.out_valid = valid_r;
   assign out.out_data  = data_r;
   assign out.out_last  = last_r;
endmodule

// File: tb/tb_random_perm_stream.sv
// Scoreboard bench for random_perm_stream: a reference shuffle model pushes expected
// sequences at request time; beats are collected and compared per scenario.
module tb_random_perm_stream;
   localparam int          LOG_N = 4;
   localparam int          N     = 16;
   localparam logic [15:0] TAPS  = 16'hB400;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic        clk = 1'b0, rst = 1'b1;
   logic        start = 1'b0, shuffle_en = 1'b0, seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic        busy, done;

   random_perm_stream_if #(.LOG_N(LOG_N)) sif ();

   random_perm_stream #(.LOG_N(LOG_N), .LFSR_W(16), .TAPS(TAPS), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .shuffle_en(shuffle_en),
      .seed_load(seed_load), .seed(seed), .busy(busy), .done(done), .out(sif.master)
   );

   always #5 clk = ~clk;

   int          errors = 0, checks = 0;
   logic [15:0] m_lfsr;
   logic [63:0] exp_q[$];
   logic [3:0]  g_data[N];
   logic        g_last[N];
   int          g_lat, g_nb, g_bad;
   bit          g_timeout;
   logic        g_done1, g_done0, g_vafter;
   logic [15:0] g_lfsr2;
   logic [3:0]  g_t15, g_t14;
   logic [63:0] ref_post_reset, seq1_ref;

   function automatic logic [63:0] got_packed();
      logic [63:0] p;
      for (int k = 0; k < N; k++) p[k*4 +: 4] = g_data[k];
      return p;
   endfunction

   function automatic int perm_errs(input logic [63:0] p);
      logic [15:0] seen = 16'h0000;
      for (int k = 0; k < N; k++) seen[p[k*4 +: 4]] = 1'b1;
      return 16 - $countones(seen);
   endfunction

   function automatic int last_errs();
      int e = 0;
      for (int k = 0; k < N; k++) if (g_last[k] !== (k == N - 1)) e++;
      return e;
   endfunction

   task automatic model_perm(input bit shuf);
      logic [3:0]  t[N];
      logic [3:0]  tmp;
      logic [63:0] p;
      int          j;
      for (int k = 0; k < N; k++) t[k] = 4'(k);
      if (shuf) begin
         for (int i = N - 1; i >= 1; i--) begin
            j    = (int'(m_lfsr[3:0]) * (i + 1)) / N;
            tmp  = t[i]; t[i] = t[j]; t[j] = tmp;
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? TAPS : 16'h0000);
         end
      end
      for (int k = 0; k < N; k++) p[k*4 +: 4] = t[k];
      exp_q.push_back(p);
   endtask

   // Called #1 after an edge while idle; returns #1 after the edge that accepts start.
   task automatic request(input bit ld, input logic [15:0] sd, input bit shuf);
      seed_load = ld; seed = sd; shuffle_en = shuf; start = 1'b1;
      if (ld) m_lfsr = (sd == 16'h0000) ? SEED : sd;
      model_perm(shuf);
      @(posedge clk); #1;
      start = 1'b0; seed_load = 1'b0; shuffle_en = 1'b0;
   endtask

   task automatic collect(input int mode, input int stop_at, input bit poke);
      int cyc = 0, held = 0;
      logic [3:0] d;
      logic l, r;
      g_nb = 0; g_bad = 0; g_timeout = 0; g_lat = -1;
      while (sif.out_valid !== 1'b1 && cyc < 100) begin
         if (poke && cyc >= 3 && cyc <= 5) begin
            start = 1'b1; seed_load = 1'b1; seed = 16'h1234; shuffle_en = 1'b0;
         end else begin
            start = 1'b0; seed_load = 1'b0;
         end
         @(posedge clk); #1; cyc++;
         if (cyc == 2) begin g_lfsr2 = dut.lfsr_r; g_t15 = dut.table_r[15]; end
         if (cyc == 3) g_t14 = dut.table_r[14];
      end
      start = 1'b0; seed_load = 1'b0;
      if (cyc >= 100) g_timeout = 1'b1; else g_lat = cyc;
      cyc = 0;
      while (g_nb < stop_at && !g_timeout) begin
         if (sif.out_valid !== 1'b1) g_bad++;
         d = sif.out_data; l = sif.out_last;
         if (mode == 1 && g_nb == 7 && held < 5) begin r = 1'b0; held++; end
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else r = 1'b1;
         sif.out_ready = r;
         @(posedge clk); #1; cyc++;
         if (r) begin g_data[g_nb] = d; g_last[g_nb] = l; g_nb++; end
         else if (sif.out_data !== d || sif.out_last !== l || sif.out_valid !== 1'b1) g_bad++;
         if (cyc > 400) g_timeout = 1'b1;
      end
      sif.out_ready = 1'b0;
      if (g_nb == N) begin
         g_done1 = done; g_vafter = sif.out_valid;
         @(posedge clk); #1;
         g_done0 = done;
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #3; rst = 1'b0;
      repeat (2) @(posedge clk);
      #3; rst = 1'b1;
      @(posedge clk); #1;
      m_lfsr = SEED;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sif.out_valid); end
      checks++; if (sif.out_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", sif.out_data); end
      checks++; if ({sif.out_last, done} !== 2'b00) begin errors++; $display("FAIL reset_last_done got=%b exp=00", {sif.out_last, done}); end
      checks++; if (dut.lfsr_r !== SEED) begin errors++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_r, SEED); end
   endtask

   task automatic test_identity();
      logic [63:0] e;
      request(1'b0, 16'h0000, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy got=%b exp=1", busy); end
      collect(0, N, 1'b0);
      e = exp_q.pop_front();
      checks++; if (g_timeout || g_lat != 2) begin errors++; $display("FAIL id_latency got=%0d exp=2", g_lat); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL id_seq got=%h exp=%h", got_packed(), e); end
      checks++; if (last_errs() != 0) begin errors++; $display("FAIL id_last got=%0d bad flags exp=0", last_errs()); end
      checks++; if ({g_done1, g_done0, g_vafter} !== 3'b100) begin errors++; $display("FAIL id_done got=%b exp=100", {g_done1, g_done0, g_vafter}); end
   endtask

   task automatic test_post_reset_shuffle();
      logic [63:0] e;
      request(1'b0, 16'h0000, 1'b1);
      collect(0, N, 1'b0);
      e = exp_q.pop_front();
      ref_post_reset = got_packed();
      checks++; if (g_timeout || g_lat != 17) begin errors++; $display("FAIL pr_latency got=%0d exp=17", g_lat); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL pr_seq got=%h exp=%h", got_packed(), e); end
      checks++; if (perm_errs(got_packed()) != 0) begin errors++; $display("FAIL pr_perm got=%0d missing exp=0", perm_errs(got_packed())); end
   endtask

   task automatic test_seeded_shuffle();
      logic [63:0] e;
      request(1'b1, 16'h0001, 1'b1);
      collect(0, N, 1'b0);
      e = exp_q.pop_front();
      seq1_ref = got_packed();
      checks++; if (g_lfsr2 !== 16'hB400) begin errors++; $display("FAIL sd_lfsr_step1 got=%h exp=b400", g_lfsr2); end
      checks++; if (g_t15 !== 4'd1) begin errors++; $display("FAIL sd_swap_i15 got=%h exp=1", g_t15); end
      checks++; if (g_t14 !== 4'd0) begin errors++; $display("FAIL sd_swap_i14 got=%h exp=0", g_t14); end
      checks++; if (g_timeout || g_lat != 17) begin errors++; $display("FAIL sd_latency got=%0d exp=17", g_lat); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL sd_seq got=%h exp=%h", got_packed(), e); end
      checks++; if (perm_errs(got_packed()) != 0) begin errors++; $display("FAIL sd_perm got=%0d missing exp=0", perm_errs(got_packed())); end
      checks++; if ({g_done1, g_done0} !== 2'b10) begin errors++; $display("FAIL sd_done got=%b exp=10", {g_done1, g_done0}); end
   endtask

   task automatic test_backpressure();
      logic [63:0] e;
      request(1'b1, 16'h0001, 1'b1);
      collect(1, N, 1'b0);
      e = exp_q.pop_front();
      checks++; if (g_timeout || g_nb != N) begin errors++; $display("FAIL bp_beats got=%0d exp=16", g_nb); end
      checks++; if (g_bad != 0) begin errors++; $display("FAIL bp_stall_stable got=%0d exp=0", g_bad); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL bp_seq_model got=%h exp=%h", got_packed(), e); end
      checks++; if (got_packed() !== seq1_ref) begin errors++; $display("FAIL bp_seq_vs_ready1 got=%h exp=%h", got_packed(), seq1_ref); end
   endtask

   task automatic test_zero_seed_ignored();
      logic [63:0] e;
      request(1'b1, 16'h0000, 1'b1);
      collect(0, N, 1'b1);
      e = exp_q.pop_front();
      checks++; if (g_timeout || g_lat != 17) begin errors++; $display("FAIL zs_latency got=%0d exp=17", g_lat); end
      checks++; if (got_packed() !== ref_post_reset) begin errors++; $display("FAIL zs_seq got=%h exp=%h", got_packed(), ref_post_reset); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL zs_seq_model got=%h exp=%h", got_packed(), e); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zs_idle_after got=%b exp=0", busy); end
   endtask

   task automatic test_mid_reset();
      logic [63:0] e;
      int bad = 0;
      request(1'b0, 16'h0000, 1'b1);
      collect(0, 6, 1'b0);
      e = exp_q.pop_front();
      #2; rst = 1'b0; #1;
      checks++; if ({sif.out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL mr_immediate got=%b exp=000", {sif.out_valid, busy, done}); end
      repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || sif.out_valid !== 1'b0) bad++; end
      #3; rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || sif.out_valid !== 1'b0) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL mr_no_done got=%0d events exp=0", bad); end
      m_lfsr = SEED;
      request(1'b0, 16'h0000, 1'b1);
      collect(0, N, 1'b0);
      e = exp_q.pop_front();
      checks++; if (got_packed() !== ref_post_reset) begin errors++; $display("FAIL mr_seq got=%h exp=%h", got_packed(), ref_post_reset); end
      checks++; if (got_packed() !== e) begin errors++; $display("FAIL mr_seq_model got=%h exp=%h", got_packed(), e); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] a, b, ea, eb;
      request(1'b0, 16'h0000, 1'b1);
      collect(0, N, 1'b0);
      a = got_packed(); ea = exp_q.pop_front();
      request(1'b0, 16'h0000, 1'b1);
      collect(0, N, 1'b0);
      b = got_packed(); eb = exp_q.pop_front();
      checks++; if (a !== ea) begin errors++; $display("FAIL b2b_first got=%h exp=%h", a, ea); end
      checks++; if (b !== eb) begin errors++; $display("FAIL b2b_second got=%h exp=%h", b, eb); end
      checks++; if (a === b) begin errors++; $display("FAIL b2b_differ got=%h exp=not %h", b, a); end
      checks++; if (perm_errs(b) != 0) begin errors++; $display("FAIL b2b_perm got=%0d missing exp=0", perm_errs(b)); end
   endtask

   initial begin
      sif.out_ready = 1'b0;
      test_reset();
      test_identity();
      test_post_reset_shuffle();
      test_seeded_shuffle();
      test_backpressure();
      test_zero_seed_ignored();
      test_mid_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/random_perm_stream.md
Name: random_perm_stream

Overview:
- Parametrised successor to the fixed 16-lane permutation wiring; generates a fresh uniformly-shuffled permutation of N = 2^LOG_N elements on each request.
- Uses an in-place Fisher-Yates shuffle driven by an internal Galois LFSR.
- Streams the elements out one per beat on a valid/ready interface.
- Sits between the seed/control logic and any consumer needing random index sequences (lane scramblers, test address generators).

Parameters:
- LOG_N, 4, element width in bits; table holds N = 2^LOG_N entries (legal 2..8).
- LFSR_W, 16, LFSR width (must be > LOG_N).
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1, LFSR reset value; also substituted when a zero seed is loaded.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request one permutation; accepted only in IDLE.
- shuffle_en  in  1  sampled with an accepted start; 0 skips the shuffle (identity output).
- seed_load  in  1  load LFSR from seed; honoured only in IDLE.
- seed  in  LFSR_W  seed value.
- busy  out  1  high in any state other than IDLE.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer ready.
- out_data  out  LOG_N  permutation element.
- out_last  out  1  marks element index N-1.
- done  out  1  one-cycle pulse the cycle after the last beat transfers.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE; lfsr = SEED; table = identity; counters = 0.
  - busy = 0, out_valid = 0, out_data = 0, out_last = 0, done = 0.
- IDLE:
  - seed_load=1 sets lfsr = seed, or SEED if seed == 0.
  - start=1 goes to INIT. If seed_load and start are high together, the load takes effect and start is also accepted; INIT/SHUFFLE use the new seed.
  - busy rises the cycle after start.
- INIT (1 cycle):
  - table[k] = k for all k; i = N-1.
  - Next state is SHUFFLE if shuffle_en was 1 at start, otherwise OUT.
- SHUFFLE (exactly N-1 cycles, i = N-1 down to 1), each cycle:
  - j = (lfsr[LOG_N-1:0] * (i+1)) >> LOG_N. Unsigned, 2*LOG_N+1-bit product, so j is in 0..i.
  - Swap table[i] and table[j] (j == i is a no-op).
  - Step the LFSR: lsb = lfsr[0]; lfsr = (lfsr >> 1) ^ (lsb ? TAPS : 0).
  - i decrements. After the i = 1 step, go to OUT with output index k = 0.
- OUT:
  - out_valid = 1, out_data = table[k], out_last = (k == N-1).
  - A beat transfers when out_valid && out_ready. k increments only on a transfer.
  - out_data and out_last are held stable while stalled.
  - After the k = N-1 transfer: go to IDLE, pulse done = 1 for one cycle, out_valid = 0.
- LFSR state persists between permutations (not re-seeded by start), so back-to-back requests differ.
- The LFSR does not step in IDLE, INIT or OUT.
- Ignored inputs: start while busy; seed_load while busy.
- Latency: start accepted at edge 0. With shuffle_en = 1, out_valid first asserts N+1 cycles later (1 INIT + N-1 SHUFFLE + 1). With shuffle_en = 0, it asserts 2 cycles later.
- With out_ready held at 1, the last beat transfers N-1 cycles after first valid.
- rst asserted mid-operation: immediate return to reset values. No partial beats or done pulse follow.
- Output is always a permutation: every value 0..N-1 appears exactly once per sequence.

Test Plan:
- Reset: drive rst=0 mid-cycle, release → busy=0, out_valid=0, out_data=0, done=0; internal lfsr=16'hACE1.
- Identity mode: start with shuffle_en=0, out_ready=1 → out_data 0,1,...,15 on consecutive cycles; out_last on 15; done one cycle after that beat; first valid 2 cycles after start.
- Seeded shuffle:
  - Stimulus: seed_load with seed=16'h0001, then start with shuffle_en=1.
  - First step: i=15 uses j=1; lfsr becomes 16'hB400. Second step: i=14 uses j=0.
  - Full 16-beat sequence matches a bit-accurate model; each value appears once; first valid 17 cycles after start.
- Backpressure: out_ready toggled randomly and held 0 for 5 cycles at k=7 → out_data stable while stalled; no lost or duplicated beats; sequence unchanged vs out_ready=1 run.
- Zero seed and ignored controls: seed_load with seed=0 → next permutation equals that after reset. start and seed_load during SHUFFLE → no effect on sequence or timing.
- Mid-operation reset: rst=0 during beat 6 → out_valid drops immediately and no done pulse. Next start after release reproduces the post-reset sequence; two back-to-back requests produce differing sequences.
